// File: rtl/counter_pkg.sv
// Shared helpers for the modulo counter: extended-width arithmetic sizing and Gray encoding.
package counter_pkg;

    // Widest counter the Gray helper supports; callers cast in and out.
    localparam int unsigned GRAY_W = 64;

    // Width of the extended adder that holds carry/borrow of a WIDTH-bit step.
    function automatic int unsigned ext_width(input int unsigned w);
        return w + 32'd1;
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Parametrised modulo counter with wrap/saturate, synchronous load and
// fully registered binary, Gray, terminal-count and saturation outputs.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 9,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             wrap,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_gray,
    output logic             tc,
    output logic             sat
);

    localparam int unsigned      EW    = ext_width(WIDTH);
    localparam logic [EW-1:0]    MAX_E = EW'(MAX);
    localparam logic [EW-1:0]    MOD_E = EW'(MAX + 32'd1);
    localparam logic [EW-1:0]    STP_E = EW'(STEP);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_W = '0;

    generate
        if (WIDTH < 2 || WIDTH > GRAY_W) begin : g_bad_width
            $error("mod_counter: WIDTH out of range");
        end
        if (MAX < 1 || (WIDTH < 32 && (MAX >> WIDTH) != 0)) begin : g_bad_max
            $error("mod_counter: MAX must satisfy 1 <= MAX < 2**WIDTH");
        end
        if (STEP < 1 || STEP > MAX) begin : g_bad_step
            $error("mod_counter: STEP must satisfy 1 <= STEP <= MAX");
        end
    endgenerate

    logic [EW-1:0]    sum_e;
    logic [EW-1:0]    diff_e;
    logic             over;
    logic             under;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             tc_nxt;
    logic             sat_nxt;

    // Next-state: load > enabled step > hold; reset is applied in the register.
    always_comb begin
        sum_e     = {1'b0, count} + STP_E;
        diff_e    = {1'b0, count} - STP_E;
        over      = (sum_e > MAX_E);
        under     = diff_e[EW-1];
        count_nxt = count;
        tc_nxt    = 1'b0;
        sat_nxt   = sat;

        if (load) begin
            count_nxt = (load_val > MAX_W) ? MAX_W : load_val;
            sat_nxt   = 1'b0;
        end else if (en) begin
            if (up) begin
                if (!over) begin
                    count_nxt = WIDTH'(sum_e);
                    sat_nxt   = 1'b0;
                end else if (wrap) begin
                    count_nxt = WIDTH'(sum_e - MOD_E);
                    tc_nxt    = 1'b1;
                    sat_nxt   = 1'b0;
                end else begin
                    // Only a repeat clamp while already parked at the bound stays silent.
                    count_nxt = MAX_W;
                    tc_nxt    = !(sat && count == MAX_W);
                    sat_nxt   = 1'b1;
                end
            end else begin
                if (!under) begin
                    count_nxt = WIDTH'(diff_e);
                    sat_nxt   = 1'b0;
                end else if (wrap) begin
                    count_nxt = WIDTH'(diff_e + MOD_E);
                    tc_nxt    = 1'b1;
                    sat_nxt   = 1'b0;
                end else begin
                    count_nxt = ZERO_W;
                    tc_nxt    = !(sat && count == ZERO_W);
                    sat_nxt   = 1'b1;
                end
            end
        end

        gray_nxt = WIDTH'(bin2gray(GRAY_W'(count_nxt)));
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            count      <= '0;
            count_gray <= '0;
            tc         <= 1'b0;
            sat        <= 1'b0;
        end else begin
            count      <= count_nxt;
            count_gray <= gray_nxt;
            tc         <= tc_nxt;
            sat        <= sat_nxt;
        end
    end

endmodule
